// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: multi-cycle MIPS fetch stage owning the PC and the instruction
// register, with a req/ack instruction-memory port and next-PC selection on retirement.
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] retired_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] branch_off_d;
  logic [31:0] next_pc_d;

  assign pc_plus4_d   = pc_q + 32'd4;
  assign branch_off_d = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc_d = pc_plus4_d;
    if (jump) begin
      next_pc_d = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc_d = pc_plus4_d + branch_off_d;
    end
  end

  // req_q stays low for the first S_FETCH cycle after reset, then is held until ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            pc_q      <= next_pc_d;
            retired_q <= retired_q + 32'd1;
            valid_q   <= 1'b0;
            req_q     <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_d;
  assign instr         = instr_q;
  assign opcode        = instr_q[31:26];
  assign instr_valid   = valid_q;
  assign retired_count = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: three fetch units with different reset PCs run in lockstep
// from shared directed stimulus; each output is compared against hand-computed values.
`default_nettype none

module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic        jump;
  logic        branch;
  logic        zero;

  logic        req_a, req_b, req_c;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] pc_a, pc_b, pc_c;
  logic [31:0] pc4_a, pc4_b, pc4_c;
  logic [31:0] instr_a, instr_b, instr_c;
  logic [5:0]  op_a, op_b, op_c;
  logic        valid_a, valid_b, valid_c;
  logic [31:0] ret_a, ret_b, ret_c;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .imem_req(req_a), .imem_addr(addr_a),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exec_done(exec_done),
    .jump(jump), .branch(branch), .zero(zero), .pc(pc_a), .pc_plus4(pc4_a),
    .instr(instr_a), .opcode(op_a), .instr_valid(valid_a), .retired_count(ret_a)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset), .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exec_done(exec_done),
    .jump(jump), .branch(branch), .zero(zero), .pc(pc_b), .pc_plus4(pc4_b),
    .instr(instr_b), .opcode(op_b), .instr_valid(valid_b), .retired_count(ret_b)
  );

  instruction_fetch_unit #(.RESET_PC(32'h4000_0008)) dut_c (
    .clk(clk), .reset(reset), .imem_req(req_c), .imem_addr(addr_c),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .exec_done(exec_done),
    .jump(jump), .branch(branch), .zero(zero), .pc(pc_c), .pc_plus4(pc4_c),
    .instr(instr_c), .opcode(op_c), .instr_valid(valid_c), .retired_count(ret_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (req_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_a !== 1'b1) check("req_timeout", {31'd0, req_a}, 32'd1);
  endtask

  // One instruction at minimum cost: ack at first request, exec_done in first S_EXEC cycle.
  task automatic run_instr(input logic [31:0] word, input logic j, input logic b, input logic z);
    wait_req();
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    @(negedge clk);
    exec_done  = 1'b1;
    jump       = j;
    branch     = b;
    zero       = z;
    @(negedge clk);
    exec_done  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    exec_done  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_pc_a",    pc_a,             32'h0000_0000);
    check("rst_pc_b",    pc_b,             32'hFFFF_FFFC);
    check("rst_instr",   instr_a,          32'd0);
    check("rst_req",     {31'd0, req_a},   32'd0);
    check("rst_valid",   {31'd0, valid_a}, 32'd0);
    check("rst_retired", ret_a,            32'd0);

    reset = 1'b0;
    #1;
    check("req_first_cycle", {31'd0, req_a}, 32'd0);
    @(negedge clk);
    check("req_up",   {31'd0, req_a}, 32'd1);
    check("addr_req", addr_a,         32'h0000_0000);
    @(negedge clk);
    check("req_held",  {31'd0, req_a}, 32'd1);
    check("addr_held", addr_a,         32'h0000_0000);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    @(negedge clk);
    check("instr_cap",    instr_a,          32'h0000_0020);
    check("opcode_cap",   {26'd0, op_a},    32'd0);
    check("valid_decode", {31'd0, valid_a}, 32'd1);
    check("req_drop",     {31'd0, req_a},   32'd0);

    // Stray ack and exec_done during S_DECODE.
    imem_rdata = 32'hDEAD_BEEF;
    exec_done  = 1'b1;
    @(negedge clk);
    check("dec_ack_ignored",  instr_a, 32'h0000_0020);
    check("dec_done_ignored", ret_a,   32'd0);
    check("dec_pc_hold",      pc_a,    32'h0000_0000);
    check("valid_exec",       {31'd0, valid_a}, 32'd1);

    exec_done = 1'b0;
    @(negedge clk);
    check("exec_ack_ignored", instr_a, 32'h0000_0020);
    check("exec_wait_pc",     pc_a,    32'h0000_0000);
    check("exec_wait_req",    {31'd0, req_a}, 32'd0);

    imem_ack  = 1'b0;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check("seq_pc",        pc_a,             32'h0000_0004);
    check("seq_retired",   ret_a,            32'd1);
    check("seq_valid_off", {31'd0, valid_a}, 32'd0);
    check("seq_req_next",  {31'd0, req_a},   32'd1);
    check("seq_addr_next", addr_a,           32'h0000_0004);
    check("instr_stable",  instr_a,          32'h0000_0020);
    check("wrap_pc",       pc_b,             32'h0000_0000);
    check("wrap_pc_plus4", pc4_b,            32'h0000_0004);

    run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    check("pc_at_10", pc_a, 32'h0000_0010);
    run_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b1);
    check("beq_taken_pc", pc_a,  32'h0000_000C);
    check("beq_taken_rc", ret_a, 32'd5);
    run_instr(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_FFFE, 1'b0, 1'b1, 1'b0);
    check("beq_not_taken_pc", pc_a,  32'h0000_0014);
    check("beq_not_taken_rc", ret_a, 32'd7);

    // Reset while a request is outstanding, with a late ack.
    wait_req();
    reset = 1'b1;
    #1;
    check("midrst_req",   {31'd0, req_a}, 32'd0);
    check("midrst_instr", instr_a,        32'd0);
    check("midrst_rc",    ret_a,          32'd0);
    check("midrst_pc",    pc_a,           32'h0000_0000);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_instr", instr_a, 32'd0);
    check("late_ack_valid", {31'd0, valid_a}, 32'd0);
    reset = 1'b0;
    #1;
    check("restart_first_req", {31'd0, req_a}, 32'd0);
    @(negedge clk);
    check("restart_req",    {31'd0, req_a}, 32'd1);
    check("restart_addr_a", addr_a,         32'h0000_0000);
    check("restart_addr_c", addr_c,         32'h4000_0008);

    run_instr(32'h0800_0100, 1'b1, 1'b1, 1'b1);
    check("jump_pc_c", pc_c,  32'h4000_0400);
    check("jump_pc_a", pc_a,  32'h0000_0400);
    check("jump_rc",   ret_c, 32'd1);

    // Reset landing on the exec_done edge must not retire the instruction.
    wait_req();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    exec_done = 1'b1;
    reset     = 1'b1;
    #1;
    check("exec_rst_pc",    pc_a,             32'h0000_0000);
    check("exec_rst_rc",    ret_a,            32'd0);
    check("exec_rst_valid", {31'd0, valid_a}, 32'd0);
    check("exec_rst_pc_c",  pc_c,             32'h4000_0008);
    @(negedge clk);
    exec_done = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
